mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_timer.sv | 29 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM state and transaction owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        IFU = 1'b0,
        LSU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/arb_timer.sv
// Response watchdog: counts WAIT cycles without a memory response and flags
// when the count reaches TIMEOUT.
module arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_hit
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_hit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU, LSU) arbiter for a single shared memory port with one
// outstanding transaction, LSU-priority with IFU anti-starvation and a response timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LSU_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                ifu_rsp_valid,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int STRK_W = (LSU_STREAK < 2) ? 1 : $clog2(LSU_STREAK + 1);

    arb_state_e           r_state;
    arb_owner_e           r_owner;
    logic [STRK_W-1:0]    r_streak;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_wen;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W/8-1:0]  r_wmask;
    logic                 r_mem_req_valid;

    logic w_idle;
    logic w_wait;
    logic w_streak_full;
    logic w_grant_lsu;
    logic w_grant_ifu;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_timer_hit;
    logic w_rsp_ok;
    logic w_rsp_err;
    logic w_rsp;

    // rst_n gates the combinational readies so every output is 0 while reset is held.
    assign w_idle        = rst_n && (r_state == IDLE);
    assign w_wait        = (r_state == WAIT);
    assign w_streak_full = (r_streak == STRK_W'(LSU_STREAK));
    assign w_grant_lsu   = w_idle && lsu_req_valid && !(ifu_req_valid && w_streak_full);
    assign w_grant_ifu   = w_idle && ifu_req_valid && !w_grant_lsu;

    assign w_timer_clear = (r_state == REQ) && mem_req_ready;
    assign w_timer_en    = w_wait && !mem_rsp_valid;

    // A real response wins over a timeout landing in the same cycle.
    assign w_rsp_ok  = w_wait && mem_rsp_valid;
    assign w_rsp_err = w_wait && !mem_rsp_valid && w_timer_hit;
    assign w_rsp     = w_rsp_ok || w_rsp_err;

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_hit    (w_timer_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_owner         <= IFU;
            r_streak        <= '0;
            r_addr          <= '0;
            r_wen           <= 1'b0;
            r_wdata         <= '0;
            r_wmask         <= '0;
            r_mem_req_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_lsu) begin
                        r_owner         <= LSU;
                        r_addr          <= lsu_addr;
                        r_wen           <= lsu_wen;
                        r_wdata         <= lsu_wdata;
                        r_wmask         <= lsu_wmask;
                        r_state         <= REQ;
                        r_mem_req_valid <= 1'b1;
                        if (ifu_req_valid && !w_streak_full) begin
                            r_streak <= r_streak + 1'b1;
                        end
                    end else if (w_grant_ifu) begin
                        r_owner         <= IFU;
                        r_addr          <= ifu_addr;
                        r_wen           <= 1'b0;
                        r_wdata         <= '0;
                        r_wmask         <= '0;
                        r_streak        <= '0;
                        r_state         <= REQ;
                        r_mem_req_valid <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_state         <= WAIT;
                        r_mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (w_rsp) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state         <= IDLE;
                    r_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ifu_req_ready = w_grant_ifu;
    assign lsu_req_ready = w_grant_lsu;

    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    assign ifu_rsp_valid = w_rsp && (r_owner == IFU);
    assign lsu_rsp_valid = w_rsp && (r_owner == LSU);
    assign rsp_err       = w_rsp_err;
    assign rsp_rdata     = w_rsp_ok ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LSU_STREAK = 4;
    localparam int TIMEOUT    = 255;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                ifu_req_valid;
    logic                ifu_req_ready;
    logic [ADDR_W-1:0]   ifu_addr;
    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic [ADDR_W-1:0]   lsu_addr;
    logic                lsu_wen;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wmask;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wen;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rdata;
    logic                ifu_rsp_valid;
    logic                lsu_rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LSU_STREAK (LSU_STREAK),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .ifu_rsp_valid (ifu_rsp_valid),
        .lsu_rsp_valid (lsu_rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a transaction is "free", "offered to memory" or "awaiting response".
    typedef enum int {M_FREE, M_OFFER, M_AWAIT} m_phase_e;
    m_phase_e            m_phase;
    bit                  m_by_lsu;
    int                  m_streak;
    int                  m_waited;
    logic [ADDR_W-1:0]   m_addr;
    bit                  m_wen;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wmask;
    bit                  e_gnt_ifu, e_gnt_lsu, e_rsp, e_err;

    task automatic model_reset();
        m_phase  = M_FREE;
        m_by_lsu = 1'b0;
        m_streak = 0;
        m_waited = 0;
        m_addr   = '0;
        m_wen    = 1'b0;
        m_wdata  = '0;
        m_wmask  = '0;
    endtask

    task automatic zero_inputs();
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
    endtask

    // Called at a falling edge with inputs set; checks, crosses one rising edge, returns at next falling edge.
    task automatic step();
        #1;
        e_gnt_lsu = (m_phase == M_FREE) && lsu_req_valid &&
                    !(ifu_req_valid && (m_streak == LSU_STREAK));
        e_gnt_ifu = (m_phase == M_FREE) && ifu_req_valid && !e_gnt_lsu;
        e_rsp     = (m_phase == M_AWAIT) && (mem_rsp_valid || (m_waited == TIMEOUT));
        e_err     = e_rsp && !mem_rsp_valid;

        check_val("ifu_req_ready", ifu_req_ready, e_gnt_ifu);
        check_val("lsu_req_ready", lsu_req_ready, e_gnt_lsu);
        check_val("mem_req_valid", mem_req_valid, m_phase == M_OFFER);
        if (m_phase == M_OFFER) begin
            check_val("mem_addr", mem_addr, m_addr);
            check_val("mem_wen", mem_wen, m_wen);
            check_val("mem_wmask", mem_wmask, m_wmask);
            if (m_by_lsu) check_val("mem_wdata", mem_wdata, m_wdata);
        end
        check_val("ifu_rsp_valid", ifu_rsp_valid, e_rsp && !m_by_lsu);
        check_val("lsu_rsp_valid", lsu_rsp_valid, e_rsp && m_by_lsu);
        check_val("rsp_err", rsp_err, e_err);
        if (e_rsp) check_val("rsp_rdata", rsp_rdata, e_err ? '0 : mem_rdata);

        @(posedge clk);
        case (m_phase)
            M_FREE: begin
                if (e_gnt_lsu) begin
                    m_by_lsu = 1'b1;
                    m_addr   = lsu_addr;
                    m_wen    = lsu_wen;
                    m_wdata  = lsu_wdata;
                    m_wmask  = lsu_wmask;
                    if (ifu_req_valid && m_streak < LSU_STREAK) m_streak++;
                    m_phase  = M_OFFER;
                end else if (e_gnt_ifu) begin
                    m_by_lsu = 1'b0;
                    m_addr   = ifu_addr;
                    m_wen    = 1'b0;
                    m_wmask  = '0;
                    m_streak = 0;
                    m_phase  = M_OFFER;
                end
            end
            M_OFFER: begin
                if (mem_req_ready) begin
                    m_phase  = M_AWAIT;
                    m_waited = 0;
                end
            end
            default: begin
                if (e_rsp) m_phase = M_FREE;
                else m_waited++;
            end
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        zero_inputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    bit                order_got[$];
    bit                order_exp[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit                found;
    int                fcyc;
    logic              ferr;
    logic [DATA_W-1:0] fdata;

    initial begin
        rst_n = 1'b0;
        zero_inputs();
        model_reset();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        check_val("rst_ifu_ready", ifu_req_ready, 1'b0);
        check_val("rst_lsu_ready", lsu_req_ready, 1'b0);
        check_val("rst_mem_valid", mem_req_valid, 1'b0);
        check_val("rst_mem_addr", mem_addr, '0);
        check_val("rst_mem_wen", mem_wen, 1'b0);
        check_val("rst_mem_wdata", mem_wdata, '0);
        check_val("rst_mem_wmask", mem_wmask, '0);
        check_val("rst_ifu_rsp", ifu_rsp_valid, 1'b0);
        check_val("rst_lsu_rsp", lsu_rsp_valid, 1'b0);
        check_val("rst_rsp_err", rsp_err, 1'b0);
        @(negedge clk);
        do_reset();

        // IFU fetch with 1-cycle memory latency
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_req_ready = 1'b1;
        #1;
        check_val("fetch_ready_c0", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0;
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0000_0413;
        #1;
        check_val("fetch_rsp_c2", ifu_rsp_valid, 1'b1);
        check_val("fetch_rdata", rsp_rdata, 32'h0000_0413);
        check_val("fetch_err", rsp_err, 1'b0);
        step();
        zero_inputs();
        step();

        // Both requesters always valid: LSU streak then one IFU
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_1000;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_2000;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            #1;
            if (lsu_req_ready || ifu_req_ready) order_got.push_back(lsu_req_ready);
            step();
        end
        check_val("order_count", order_got.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("order_%0d", i), (i < order_got.size()) ? order_got[i] : 1'bx, order_exp[i]);
        end

        // LSU store held in REQ while memory stalls
        do_reset();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        #1;
        check_val("store_ready", lsu_req_ready, 1'b1);
        step();
        lsu_req_valid = 1'b0;
        lsu_addr      = 32'h1234_5678;
        lsu_wdata     = 32'h0BAD_F00D;
        lsu_wmask     = 4'h3;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            #1;
            check_val("stall_valid", mem_req_valid, 1'b1);
            check_val("stall_addr", mem_addr, 32'h8000_1000);
            check_val("stall_wen", mem_wen, 1'b1);
            check_val("stall_wdata", mem_wdata, 32'hDEAD_BEEF);
            check_val("stall_wmask", mem_wmask, 4'hF);
            step();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0000_0001;
        step();
        zero_inputs();

        // Timeout, then a late response that must be ignored
        do_reset();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_2000;
        mem_req_ready = 1'b1;
        found         = 1'b0;
        fcyc          = -1;
        ferr          = 1'b0;
        fdata         = '1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 1) lsu_req_valid = 1'b0;
            #1;
            if (lsu_rsp_valid && !found) begin
                found = 1'b1;
                fcyc  = cyc;
                ferr  = rsp_err;
                fdata = rsp_rdata;
            end
            step();
            if (found) break;
        end
        check_val("timeout_seen", found, 1'b1);
        check_val("timeout_cycle", fcyc, 2 + TIMEOUT);
        check_val("timeout_err", ferr, 1'b1);
        check_val("timeout_rdata", fdata, '0);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hCAFE_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("late_lsu_rsp", lsu_rsp_valid, 1'b0);
            check_val("late_ifu_rsp", ifu_rsp_valid, 1'b0);
            step();
        end

        // Reset asserted while awaiting a response
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        mem_req_ready = 1'b1;
        step();
        ifu_req_valid = 1'b0;
        step();
        mem_rsp_valid = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        rst_n         = 1'b0;
        #1;
        check_val("midrst_ifu_rsp", ifu_rsp_valid, 1'b0);
        check_val("midrst_lsu_rsp", lsu_rsp_valid, 1'b0);
        check_val("midrst_err", rsp_err, 1'b0);
        check_val("midrst_mem_valid", mem_req_valid, 1'b0);
        check_val("midrst_ifu_ready", ifu_req_ready, 1'b0);
        check_val("midrst_lsu_ready", lsu_req_ready, 1'b0);
        @(posedge clk);
        #1;
        check_val("midrst_ifu_rsp2", ifu_rsp_valid, 1'b0);
        @(negedge clk);
        model_reset();
        zero_inputs();
        rst_n         = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0080;
        mem_req_ready = 1'b1;
        #1;
        check_val("postrst_ifu_ready", ifu_req_ready, 1'b1);
        step();
        ifu_req_valid = 1'b0;
        step();
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0000_0013;
        step();
        zero_inputs();

        // Randomized traffic; requesters hold their request until accepted
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!ifu_req_valid && ($urandom_range(0, 2) != 0)) begin
                ifu_req_valid = 1'b1;
                ifu_addr      = $urandom;
            end
            if (!lsu_req_valid && ($urandom_range(0, 2) != 0)) begin
                lsu_req_valid = 1'b1;
                lsu_addr      = $urandom;
                lsu_wen       = 1'($urandom_range(0, 1));
                lsu_wdata     = $urandom;
                lsu_wmask     = 4'($urandom_range(0, 15));
            end
            mem_req_ready = ($urandom_range(0, 3) != 0);
            mem_rsp_valid = ($urandom_range(0, 2) == 0);
            mem_rdata     = $urandom;
            step();
            if (e_gnt_ifu) ifu_req_valid = 1'b0;
            if (e_gnt_lsu) lsu_req_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
